uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter on the SoC data bus, sitting downstream of the byte-lane memory interface and alongside the data RAM. It shares the RAM's write-strobe/read-enable port style: a store to its address window queues a byte in a small TX FIFO, and a serializer shifts it out as 8N1 on `txd` at a programmable divisor. Software polls a status register to check FIFO space and transmitter activity.

## Interface
- Parameters
- `DW`, 32, data width
- `AW`, 32, address width
- `BASE_ADDR`, 32'h1000_0000, 16-byte aligned window base
- `FIFO_DEPTH`, 4, TX FIFO entries (power of 2, ≥2)
- `DIV_RESET`, 16'd868, reset value of baud divisor (clk cycles per bit)
- Ports
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: synchronous, active-high reset
- `wen` in 4: byte write strobes, lane i = `w_data[8i+7:8i]`
- `w_addr` in AW: write byte address
- `w_data` in DW: write data
- `ren` in 1: read enable
- `r_addr` in AW: read byte address
- `r_data` out DW: registered read data
- `txd` out 1: serial output, idle high

## Operation
- Select: `addr[AW-1:4] == BASE_ADDR[AW-1:4]`, computed separately for `w_addr` and `r_addr`. Offset = `addr[3:2]`. Unselected accesses are ignored.
- 0x0 TXDATA, write-only, reads 0. A write with `wen[0]` set pushes `w_data[7:0]` if the FIFO is not full at the start of that cycle. Otherwise the byte is silently dropped: no stall, no error.
- 0x4 STATUS, read-only. bit0 busy (FSM ≠ IDLE); bit1 full; bit2 empty; bits[7:4] FIFO count, zero-extended. All other bits 0.
- 0x8 BAUD_DIV, R/W, 16 bits. `wen[0]` writes [7:0] and `wen[1]` writes [15:8]; upper lanes are ignored. A stored value of 0 behaves as 1.
- 0xC reserved. Reads 0; writes are ignored.
- FIFO: circular buffer, read/write pointers of log2(DEPTH) bits plus a count register. Pointers wrap modulo DEPTH.
- Serializer FSM: IDLE → START → DATA → STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `txd`=0 for one bit time.
  - DATA: 8 bits, LSB first, each held one bit time. A 3-bit index counts 0..7.
  - STOP: `txd`=1 for one bit time. On its last cycle: if the FIFO is non-empty, pop and go to START (no idle gap); else go to IDLE.
- Bit time: a 16-bit counter counts 0..div-1. The divisor is sampled at each bit boundary, so a BAUD_DIV write mid-frame takes effect at the next bit.
- Push and pop in the same cycle: both occur and count is unchanged. The full check uses the pre-pop count.
- `r_data`: registered. When `ren` is set and selected, the value is the register contents at cycle N; otherwise 0, so the top level may OR peripheral read buses.

## Timing
- Reset: `txd`=1, FSM=IDLE, FIFO empty (count 0, pointers 0), BAUD_DIV=`DIV_RESET`, `r_data`=0, shift register 0.
- Assertion of `rst` mid-frame aborts the frame immediately: next cycle `txd`=1 and the FIFO is flushed.
- Write to TXDATA at cycle N with FSM idle and FIFO empty:
  - count=1 at N+1
  - pop at N+1, START entered at N+2
  - `txd` low from N+2 for div cycles
- Frame length: exactly 10×div cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Read latency: 1 cycle (`ren` at N → `r_data` valid at N+1). STATUS reflects state at cycle N, before that cycle's edge updates.
- Writes and reads in the same cycle to different offsets are independent.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles; then `txd`=1, STATUS read = 0x0000_0004, BAUD_DIV read = 868.
- Single byte: BAUD_DIV=4, write 0xA5 to TXDATA → `txd` low from N+2 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles. Busy clears after 40 cycles.
- Overflow: div=16, write 0x01..0x06 on consecutive cycles → first pops at N+1. Bytes 0x01..0x05 transmit in order and 0x06 is dropped (count=4 at full). STATUS full bit seen mid-burst.
- Back-to-back: two bytes queued → no high gap between stop of byte 1 and start of byte 2. Total 20×div cycles.
- Partial/unmapped writes: write 0x1234_5678 to BAUD_DIV with `wen`=4'b0001 → reads 0x0000_0378 (from 868=0x0364). Write to 0xC and to BASE_ADDR+0x10 → no state change; reads return 0.
- Reset mid-frame: assert `rst` during DATA with 2 bytes queued → `txd`=1 next cycle, STATUS=0x4, no further frames.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// Byte-lane bus port shared by the memory-mapped peripherals: write strobes,
// a read enable and a registered read-data return.
interface uart_tx_mmio_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [3:0]    wen;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          ren;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    modport master (
        output wen, w_addr, w_data, ren, r_addr,
        input  r_data
    );

    modport slave (
        input  wen, w_addr, w_data, ren, r_addr,
        output r_data
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores queue bytes in a small
// FIFO that a divisor-paced serializer drains onto txd.
module uart_tx_mmio #(
    parameter int              DW         = 32,
    parameter int              AW         = 32,
    parameter logic [AW-1:0]   BASE_ADDR  = 32'h1000_0000,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [15:0]     DIV_RESET  = 16'd868
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_mmio_if.slave    bus,
    output logic             txd
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_r;
    logic          txd_r;
    logic [7:0]    shift_r;
    logic [2:0]    bit_idx_r;
    logic [15:0]   bit_cnt_r;
    logic [15:0]   bit_div_r;
    logic [15:0]   baud_div_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [DW-1:0] r_data_r;

    logic          w_sel_s;
    logic          r_sel_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          busy_s;
    logic          bit_last_s;
    logic [15:0]   div_eff_s;
    logic [3:0]    status_cnt_s;
    logic [DW-1:0] status_s;
    logic [DW-1:0] rd_mux_s;
    logic          unused_s;

    // Address decode, FIFO handshakes and bit-timing status
    always_comb begin
        w_sel_s      = (bus.w_addr[AW-1:4] == BASE_ADDR[AW-1:4]);
        r_sel_s      = (bus.r_addr[AW-1:4] == BASE_ADDR[AW-1:4]);
        full_s       = (count_r == CW'(FIFO_DEPTH));
        empty_s      = (count_r == {CW{1'b0}});
        busy_s       = (state_r != S_IDLE);
        bit_last_s   = (bit_cnt_r == (bit_div_r - 16'd1));
        div_eff_s    = (baud_div_r == 16'd0) ? 16'd1 : baud_div_r;
        // Full is judged on the count before any same-cycle pop
        push_s       = w_sel_s && (bus.w_addr[3:2] == 2'd0) && bus.wen[0] && !full_s;
        pop_s        = !empty_s && ((state_r == S_IDLE) ||
                                    ((state_r == S_STOP) && bit_last_s));
        status_cnt_s = 4'(count_r);
        status_s     = DW'({24'd0, status_cnt_s, 1'b0, empty_s, full_s, busy_s});
        unused_s     = ^{bus.w_data[DW-1:16], bus.w_addr[1:0], bus.r_addr[1:0], bus.wen[3:2]};
    end

    // Read-data mux; TXDATA and the reserved slot read as zero
    always_comb begin
        rd_mux_s = {DW{1'b0}};
        case (bus.r_addr[3:2])
            2'd1:    rd_mux_s = status_s;
            2'd2:    rd_mux_s = DW'(baud_div_r);
            default: rd_mux_s = {DW{1'b0}};
        endcase
    end

    // FIFO pointers, occupancy and the baud divisor register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            baud_div_r <= DIV_RESET;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (w_sel_s && (bus.w_addr[3:2] == 2'd2) && bus.wen[0]) begin
                baud_div_r[7:0] <= bus.w_data[7:0];
            end
            if (w_sel_s && (bus.w_addr[3:2] == 2'd2) && bus.wen[1]) begin
                baud_div_r[15:8] <= bus.w_data[15:8];
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.w_data[7:0];
        end
    end

    // Serializer: txd is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            txd_r     <= 1'b1;
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
            bit_cnt_r <= 16'd0;
            bit_div_r <= 16'd1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    txd_r     <= 1'b1;
                    bit_cnt_r <= 16'd0;
                    if (pop_s) begin
                        shift_r   <= fifo_mem_r[rd_ptr_r];
                        bit_div_r <= div_eff_s;
                        txd_r     <= 1'b0;
                        state_r   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_last_s) begin
                        bit_cnt_r <= 16'd0;
                        bit_div_r <= div_eff_s;
                        bit_idx_r <= 3'd0;
                        txd_r     <= shift_r[0];
                        state_r   <= S_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_last_s) begin
                        bit_cnt_r <= 16'd0;
                        bit_div_r <= div_eff_s;
                        if (bit_idx_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= S_STOP;
                        end else begin
                            txd_r     <= shift_r[bit_idx_r + 3'd1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_last_s) begin
                        bit_cnt_r <= 16'd0;
                        bit_div_r <= div_eff_s;
                        // Chain straight into the next start bit when data waits
                        if (pop_s) begin
                            shift_r <= fifo_mem_r[rd_ptr_r];
                            txd_r   <= 1'b0;
                            state_r <= S_START;
                        end else begin
                            txd_r   <= 1'b1;
                            state_r <= S_IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                default: begin
                    txd_r   <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Registered read port, zero when not addressed so buses can be OR-ed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_r <= {DW{1'b0}};
        end else if (bus.ren && r_sel_s) begin
            r_data_r <= rd_mux_s;
        end else begin
            r_data_r <= {DW{1'b0}};
        end
    end

    assign bus.r_data = r_data_r;
    assign txd        = txd_r;

endmodule
